// File: rtl/lsu_align.sv
// lsu_align: turns byte/half/word loads and stores into word accesses (RMW merge, lane extract, extension).
// Optional macro LSU_MISALIGN_SPLIT_EN: perform misaligned accesses (split when crossing); otherwise reject them.
module lsu_align (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2} state_t;

  state_t      state_r, state_nxt_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_addr_r;
  logic [31:0] asm_r;
  logic [31:0] rdata_r;
  logic        done_r;
  logic        err_r;

  logic [3:0]  nbytes_s;
  logic        cross_s;
  logic        misaligned_s;
  logic        reject_s;
  logic        active_s;
  logic        hi_s;
  logic        last_s;
  logic [31:0] merged_s;
  logic [31:0] asm_nxt_s;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  // Lane belongs to the access when its position in the two-word window lies in [off, off+n).
  function automatic logic lane_hit(input logic hi, input logic [1:0] lane,
                                    input logic [1:0] off, input logic [3:0] n);
    logic [3:0] pos;
    pos = {1'b0, hi, lane};
    return (pos >= {2'b00, off}) && (pos < ({2'b00, off} + n));
  endfunction

  function automatic logic [1:0] lane_byte(input logic hi, input logic [1:0] lane, input logic [1:0] off);
    logic [2:0] d;
    d = {hi, lane} - {1'b0, off};
    return d[1:0];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Request decode: size, crossing and rejection of the registered access
  always_comb begin
    nbytes_s     = size_bytes(funct3_r[1:0]);
    cross_s      = ({2'b00, off_r} + nbytes_s) > 4'd4;
    misaligned_s = ({2'b00, off_r} & (nbytes_s - 4'd1)) != 4'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    reject_s     = 1'b0;
`else
    reject_s     = misaligned_s;
`endif
    active_s     = (state_r == ACC0) || (state_r == ACC1);
    hi_s         = (state_r == ACC1);
    last_s       = (state_r == ACC1) || ((state_r == ACC0) && !(cross_s && !reject_s));
  end

  // Store lane merge and load byte assembly for the current word
  always_comb begin
    merged_s  = mem_rdata;
    asm_nxt_s = asm_r;
    for (int l = 0; l < 4; l++) begin
      if (active_s && lane_hit(hi_s, l[1:0], off_r, nbytes_s)) begin
        merged_s[{l[1:0], 3'b000} +: 8] = wdata_r[{lane_byte(hi_s, l[1:0], off_r), 3'b000} +: 8];
        asm_nxt_s[{lane_byte(hi_s, l[1:0], off_r), 3'b000} +: 8] = mem_rdata[{l[1:0], 3'b000} +: 8];
      end else begin
        merged_s[{l[1:0], 3'b000} +: 8] = mem_rdata[{l[1:0], 3'b000} +: 8];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_nxt_s = ACC0;
        else           state_nxt_s = IDLE;
      end
      ACC0: begin
        if (last_s) state_nxt_s = IDLE;
        else        state_nxt_s = ACC1;
      end
      ACC1:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request capture, load assembly and completion registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      funct3_r   <= 3'd0;
      off_r      <= 2'd0;
      wdata_r    <= 32'd0;
      mem_addr_r <= 32'd0;
      asm_r      <= 32'd0;
      rdata_r    <= 32'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= last_s;
      err_r   <= last_s && reject_s;
      if (state_r == IDLE && req_valid) begin
        we_r       <= req_we;
        funct3_r   <= req_funct3;
        off_r      <= req_addr[1:0];
        wdata_r    <= req_wdata;
        mem_addr_r <= {req_addr[31:2], 2'b00};
        asm_r      <= 32'd0;
      end else if (active_s) begin
        asm_r <= asm_nxt_s;
        // Second word of a split access; wraps naturally at the top of memory.
        if (!last_s) mem_addr_r <= mem_addr_r + 32'd4;
      end
      if (last_s && !we_r) rdata_r <= reject_s ? 32'd0 : extend(asm_nxt_s, funct3_r);
    end
  end

  assign ready        = (state_r == IDLE);
  assign done         = done_r;
  assign misalign_err = err_r;
  assign rdata        = rdata_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = merged_s;
  // A reset arriving mid-access must suppress the pending write.
  assign mem_we       = active_s && we_r && !reject_s && !reset;

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the RISC-V core's execute/memory stage and the word-addressed data memory. It turns byte, halfword and word loads and stores into whole-word memory accesses. Stores are read-modify-write merges. Loads have byte lanes extracted and are sign- or zero-extended. Accesses that straddle a word boundary are split into two sequential word accesses by a small FSM, which stalls the core through a ready/done handshake.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: core access request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3.
  - Bits [1:0] give size: 00 byte, 01 half, 1x word.
  - Bit [2] selects unsigned load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `ready` output 1: unit idle; a request is accepted when `req_valid & ready` at a rising edge.
- `done` output 1: one-cycle pulse when an access completes.
- `rdata` output 32: extended load result.
- `misalign_err` output 1: one-cycle pulse, coincident with `done`, for a rejected misaligned access.
- `mem_addr` output 32: word address to data memory, always 4-byte aligned.
- `mem_wdata` output 32: merged word to data memory.
- `mem_we` output 1: data memory write enable.
- `mem_rdata` input 32: combinational read data from data memory at `mem_addr`.

## Operation
- **States:** IDLE, ACC0, ACC1.
- **Acceptance (IDLE):** `req_valid & ready` registers we, funct3, addr, wdata. The next state is ACC0.
- **Request registers:**
  - Byte offset `o` = addr[1:0].
  - Byte count `n` = 1, 2 or 4.
  - `cross` = (o + n > 4).
- **ACC0:**
  - `mem_addr` = {addr[31:2], 2'b00}.
  - Loads capture lanes o..min(3, o+n-1) of `mem_rdata`.
  - Stores drive `mem_we` = 1 and `mem_wdata` = `mem_rdata` with lanes o..min(3, o+n-1) replaced by the low store bytes, little-endian.
  - If `cross`, the next state is ACC1; otherwise IDLE with completion.
- **ACC1:**
  - `mem_addr` = ACC0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - The remaining o+n-4 bytes go to lanes 0 and up.
  - The load/store handling matches ACC0.
  - The next state is IDLE with completion.
- **Completion:**
  - `done` pulses high in the first IDLE cycle.
  - `rdata` is updated on that same edge, then held until the next completion.
  - Load result: assembled bytes, sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1). Words are not extended.
  - A store leaves `rdata` unchanged.
- **Signals outside ACC0/ACC1:** `mem_we` = 0. `mem_addr` holds its last value (don't-care). `mem_wdata` = `mem_rdata`.
- **`req_valid` while not ready:** ignored. The core must hold the request until `ready`.
- **Registered-request rule:** the unit uses only the registered request; later changes to `req_*` have no effect.

## Timing
- **Reset:**
  - state IDLE
  - `ready` = 1
  - `done` = 0
  - `misalign_err` = 0
  - `rdata` = 0
  - `mem_we` = 0
  - `mem_addr` = 0
- **Reset mid-access:** the FSM goes to IDLE on the next edge with no `done`. An ACC0 store already written stays written, and ACC1 is not performed.
- **Aligned or non-crossing access:** accepted at edge N. ACC0 runs in cycle N+1. `done` and `ready` are high in cycle N+2.
- **Crossing access:** ACC0 runs in N+1 and ACC1 in N+2. `done` is high in N+3.
- **Back-to-back:** a request presented while `done` is high is accepted on that edge. Sustained throughput is one aligned access per 2 cycles.
- **Memory-side timing:**
  - `mem_wdata` merge and load capture use `mem_rdata` from the same cycle.
  - The memory write occurs on the rising edge ending the ACC cycle.

## Configuration
- **Macro:** `LSU_MISALIGN_SPLIT_EN`.
- **Defined:**
  - Crossing accesses use ACC1 as above.
  - Non-crossing misaligned accesses (e.g. a halfword at offset 1) complete in ACC0.
  - `misalign_err` is constant 0.
- **Undefined:**
  - Any access with addr not a multiple of n goes IDLE→ACC0→IDLE with `mem_we` held 0.
  - `done` and `misalign_err` pulse together.
  - A load sets `rdata` = 0.
  - ACC1 is unreachable.

## Test plan
- **Aligned word:** SW 0xDEADBEEF to 0x10, then LW 0x10 → `rdata` = 0xDEADBEEF. `done` pulses 2 cycles after each accept, and `mem_we` is high only in the store's ACC0.
- **Byte store and load:** word 0x10 = 0x11223344, then SB 0x0000_00A5 to 0x13.
  - Memory word becomes 0xA5223344.
  - LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- **Crossing halfword (macro defined):** words 0x20/0x24 = 0, then SH 0xBEEF to 0x23.
  - Word 0x20 = 0xEF000000 and word 0x24 = 0x000000BE.
  - LH 0x23 → 0xFFFFBEEF, with `done` 3 cycles after accept.
- **Misaligned rejected (macro undefined):** LW 0x22 and SH to 0x23.
  - `misalign_err` pulses with `done`; LW returns `rdata` = 0.
  - `mem_we` never asserts, and memory is unchanged.
- **Reset mid-access:** crossing SW to 0x1E, then `reset` asserted during ACC1.
  - Word 0x1C is written; word 0x20 is unchanged.
  - No `done`; `ready` is 1 and `rdata` is 0 after reset.
- **Busy and wrap:** change `req_addr`/`req_wdata` while busy → completion uses the accepted values. Crossing LW at 0xFFFFFFFE → ACC1 `mem_addr` = 0x00000000.
